// File: rtl/raster_core_if.sv
// Drawing-command, raw-pixel-write and front-buffer read bundle of raster_core.
// master = plot controller / symbol drawer / scan-out side, slave = raster_core.
interface raster_core_if #(
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int ADDR_WIDTH = 19
);
    logic                  fill_start;
    logic                  fill_ready;
    logic                  line_start;
    logic                  line_ready;
    logic [X_WIDTH-1:0]    x1;
    logic [X_WIDTH-1:0]    x2;
    logic [Y_WIDTH-1:0]    y1;
    logic [Y_WIDTH-1:0]    y2;
    logic                  ext_write_enable;
    logic [ADDR_WIDTH-1:0] ext_write_addr;
    logic                  ext_write_data;
    logic                  swap;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_data;

    modport master (
        output fill_start, line_start, x1, x2, y1, y2,
        output ext_write_enable, ext_write_addr, ext_write_data,
        output swap, read_addr,
        input  fill_ready, line_ready, read_data
    );

    modport slave (
        input  fill_start, line_start, x1, x2, y1, y2,
        input  ext_write_enable, ext_write_addr, ext_write_data,
        input  swap, read_addr,
        output fill_ready, line_ready, read_data
    );
endinterface

// File: rtl/raster_core.sv
// Pixel raster back end: clear engine, Bresenham line engine and a 1 bpp
// double-buffered frame buffer. Drawing goes to the back bank, scan-out
// reads the front bank, swap exchanges them.
//
// Fill FSM
//   state     | meaning
//   FILL_IDLE | fill_ready=1, waiting for fill_start
//   FILL_RUN  | writing 0 to address fill_cnt_q, one pixel per cycle
//
// Line FSM
//   state     | meaning
//   LINE_IDLE | line_ready=1, waiting for line_start
//   LINE_RUN  | writing 1 at (cur_x,cur_y) then taking one Bresenham step
module raster_core #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
) (
    input  logic         clk,
    input  logic         rst,
    raster_core_if.slave bus
);
    localparam int X_WIDTH      = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH      = $clog2(VER_ACTIVE_PIXELS);
    localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT);
    // two guard bits: one for the sign, one so dx-dy never overflows
    localparam int CW           = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(PIXELS_COUNT - 1);
    // one bit wider so the compare also works when PIXELS_COUNT is a power of two
    localparam logic [ADDR_WIDTH:0]   PIX_EXT   = (ADDR_WIDTH + 1)'(PIXELS_COUNT);
    localparam logic [ADDR_WIDTH-1:0] HOR_ADDR  = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
    localparam logic signed [CW-1:0]  HOR_S     = CW'(HOR_ACTIVE_PIXELS);
    localparam logic signed [CW-1:0]  VER_S     = CW'(VER_ACTIVE_PIXELS);
    localparam logic signed [CW-1:0]  ONE       = CW'(1);
    localparam logic signed [CW-1:0]  ZERO      = CW'(0);

    typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;
    typedef enum logic {LINE_IDLE, LINE_RUN} line_state_e;

    fill_state_e           fill_state_q, fill_state_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                  fill_last, fill_ready, fill_we;

    line_state_e           line_state_q, line_state_d;
    logic signed [CW-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [CW-1:0]  end_x_q, end_x_d, end_y_q, end_y_d;
    logic signed [CW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [CW-1:0]  in_x1, in_y1, in_x2, in_y2, dx_abs, dy_abs;
    logic signed [CW:0]    e2;
    logic                  step_x, step_y, line_at_end, line_in_bounds;
    logic                  line_ready, line_we;
    logic [ADDR_WIDTH-1:0] line_addr;

    logic                  wr_en, wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  ext_in_range, read_in_range;
    logic                  front_sel_q, read_data_q;
    logic                  bank0_mem [PIXELS_COUNT];
    logic                  bank1_mem [PIXELS_COUNT];

    assign fill_last = (fill_cnt_q == FILL_LAST);

    // fill FSM: state register
    always_ff @(posedge clk) begin
        if (rst) fill_state_q <= FILL_IDLE;
        else     fill_state_q <= fill_state_d;
    end

    // fill FSM: next state; a start while running is ignored
    always_comb begin
        fill_state_d = fill_state_q;
        case (fill_state_q)
            FILL_IDLE: if (bus.fill_start) fill_state_d = FILL_RUN;
            FILL_RUN:  if (fill_last)      fill_state_d = FILL_IDLE;
            default:                       fill_state_d = FILL_IDLE;
        endcase
    end

    // fill FSM: outputs
    always_comb begin
        fill_ready = 1'b0;
        fill_we    = 1'b0;
        case (fill_state_q)
            FILL_IDLE: fill_ready = 1'b1;
            FILL_RUN:  fill_we    = 1'b1;
            default:   fill_ready = 1'b1;
        endcase
    end

    // fill address counter: parked at 0 while idle, so a start begins at 0
    always_comb begin
        if (fill_state_q == FILL_RUN) fill_cnt_d = fill_cnt_q + 1'b1;
        else                          fill_cnt_d = '0;
    end

    // fill address register
    always_ff @(posedge clk) begin
        if (rst) fill_cnt_q <= '0;
        else     fill_cnt_q <= fill_cnt_d;
    end

    assign in_x1  = signed'(CW'(bus.x1));
    assign in_y1  = signed'(CW'(bus.y1));
    assign in_x2  = signed'(CW'(bus.x2));
    assign in_y2  = signed'(CW'(bus.y2));
    assign dx_abs = (in_x2 >= in_x1) ? (in_x2 - in_x1) : (in_x1 - in_x2);
    assign dy_abs = (in_y2 >= in_y1) ? (in_y2 - in_y1) : (in_y1 - in_y2);

    assign e2             = signed'({err_q, 1'b0});
    assign step_x         = (e2 >= dy_q);
    assign step_y         = (e2 <= dx_q);
    assign line_at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    assign line_in_bounds = (cur_x_q < HOR_S) && (cur_y_q < VER_S);
    assign line_addr      = ADDR_WIDTH'(cur_y_q[Y_WIDTH-1:0]) * HOR_ADDR
                          + ADDR_WIDTH'(cur_x_q[X_WIDTH-1:0]);

    // line FSM: state register
    always_ff @(posedge clk) begin
        if (rst) line_state_q <= LINE_IDLE;
        else     line_state_q <= line_state_d;
    end

    // line FSM: next state; the run ends in the cycle that writes the endpoint
    always_comb begin
        line_state_d = line_state_q;
        case (line_state_q)
            LINE_IDLE: if (bus.line_start) line_state_d = LINE_RUN;
            LINE_RUN:  if (line_at_end)    line_state_d = LINE_IDLE;
            default:                       line_state_d = LINE_IDLE;
        endcase
    end

    // line FSM: outputs; off-screen points are stepped through but not written
    always_comb begin
        line_ready = 1'b0;
        line_we    = 1'b0;
        case (line_state_q)
            LINE_IDLE: line_ready = 1'b1;
            LINE_RUN:  line_we    = line_in_bounds;
            default:   line_ready = 1'b1;
        endcase
    end

    // line datapath: latch endpoints on start, one Bresenham step per run cycle
    always_comb begin
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        end_x_d  = end_x_q;
        end_y_d  = end_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        if (line_state_q == LINE_IDLE && bus.line_start) begin
            cur_x_d  = in_x1;
            cur_y_d  = in_y1;
            end_x_d  = in_x2;
            end_y_d  = in_y2;
            dx_d     = dx_abs;
            dy_d     = -dy_abs;
            sx_neg_d = (in_x2 < in_x1);
            sy_neg_d = (in_y2 < in_y1);
            err_d    = dx_abs - dy_abs;
        end else if (line_state_q == LINE_RUN && !line_at_end) begin
            if (step_x) cur_x_d = sx_neg_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
            if (step_y) cur_y_d = sy_neg_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
            err_d = err_q + (step_x ? dy_q : ZERO) + (step_y ? dx_q : ZERO);
        end
    end

    // line datapath registers; only meaningful while running, so no reset
    always_ff @(posedge clk) begin
        cur_x_q  <= cur_x_d;
        cur_y_q  <= cur_y_d;
        end_x_q  <= end_x_d;
        end_y_q  <= end_y_d;
        dx_q     <= dx_d;
        dy_q     <= dy_d;
        sx_neg_q <= sx_neg_d;
        sy_neg_q <= sy_neg_d;
        err_q    <= err_d;
    end

    assign ext_in_range  = ({1'b0, bus.ext_write_addr} < PIX_EXT);
    assign read_in_range = ({1'b0, bus.read_addr} < PIX_EXT);

    // back-bank write port: fill > line > external; engines are silenced by rst
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = 1'b0;
        if (fill_we && !rst) begin
            wr_en   = 1'b1;
            wr_addr = fill_cnt_q;
            wr_data = 1'b0;
        end else if (line_we && !rst) begin
            wr_en   = 1'b1;
            wr_addr = line_addr;
            wr_data = 1'b1;
        end else if (bus.ext_write_enable && ext_in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.ext_write_addr;
            wr_data = bus.ext_write_data;
        end
    end

    // frame memory; a write in a swap cycle still uses the old back bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel_q) bank0_mem[wr_addr] <= wr_data;
            else             bank1_mem[wr_addr] <= wr_data;
        end
    end

    // registered front-bank read; a swap cycle still reads the old front bank
    always_ff @(posedge clk) begin
        if (rst)                 read_data_q <= 1'b0;
        else if (!read_in_range) read_data_q <= 1'b0;
        else if (front_sel_q)    read_data_q <= bank1_mem[bus.read_addr];
        else                     read_data_q <= bank0_mem[bus.read_addr];
    end

    // front bank select
    always_ff @(posedge clk) begin
        if (rst)           front_sel_q <= 1'b0;
        else if (bus.swap) front_sel_q <= ~front_sel_q;
    end

    assign bus.fill_ready = fill_ready;
    assign bus.line_ready = line_ready;
    assign bus.read_data  = read_data_q;
endmodule

// File: tb/tb_raster_core.sv
// Self-checking bench for raster_core on a reduced 20x12 raster (x up to 31 and
// y up to 15 are reachable, so clipping is exercised). A bank-level model of
// both frame buffers is updated from the drawing rules and compared on reads.
module tb_raster_core;
    localparam int HOR = 20;
    localparam int VER = 12;
    localparam int PIX = HOR * VER;
    localparam int XW  = 5;
    localparam int YW  = 4;
    localparam int AW  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raster_core_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) bus ();

    raster_core #(.HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit model [2][PIX];
    int front = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // textbook integer Bresenham, plotting into the model's back bank
    task automatic model_line(input int x1, input int y1, input int x2, input int y2);
        int x, y, dx, dy, sx, sy, err, e2, back;
        back = 1 - front;
        x = x1; y = y1;
        dx = iabs(x2 - x1);
        dy = -iabs(y2 - y1);
        sx = (x1 < x2) ? 1 : -1;
        sy = (y1 < y2) ? 1 : -1;
        err = dx + dy;
        for (int guard = 0; guard < 100; guard++) begin
            if (x < HOR && y < VER) model[back][y * HOR + x] = 1'b1;
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // clear the back bank; re-requests mid-run must be ignored
    task automatic do_fill(input bit with_line);
        int n;
        bus.fill_start = 1'b1;
        if (with_line) begin
            bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
            bus.line_start = 1'b1;
        end
        tick;
        bus.fill_start = 1'b0;
        bus.line_start = 1'b0;
        n = 0;
        while (bus.fill_ready !== 1'b1 && n < PIX + 8) begin
            bus.fill_start = (n == 5);
            tick;
            bus.fill_start = 1'b0;
            n++;
        end
        chk("fill_len", n, PIX);
        if (with_line) chk("prio_line_ready", bus.line_ready, 1);
        for (int a = 0; a < PIX; a++) model[1 - front][a] = 1'b0;
    endtask

    task automatic do_line(input int x1, input int y1, input int x2, input int y2, input bit poke);
        int n, len;
        bus.x1 = XW'(x1); bus.y1 = YW'(y1);
        bus.x2 = XW'(x2); bus.y2 = YW'(y2);
        bus.line_start = 1'b1;
        tick;
        bus.line_start = 1'b0;
        bus.x1 = XW'($urandom); bus.y1 = YW'($urandom);
        bus.x2 = XW'($urandom); bus.y2 = YW'($urandom);
        n = 0;
        while (bus.line_ready !== 1'b1 && n < 64) begin
            bus.line_start = poke && (n == 0);
            tick;
            bus.line_start = 1'b0;
            n++;
        end
        len = ((iabs(x2 - x1) > iabs(y2 - y1)) ? iabs(x2 - x1) : iabs(y2 - y1)) + 1;
        chk("line_len", n, len);
        model_line(x1, y1, x2, y2);
    endtask

    task automatic do_swap;
        bus.swap = 1'b1;
        tick;
        bus.swap = 1'b0;
        front = 1 - front;
    endtask

    task automatic ext_wr(input int addr, input bit data);
        bus.ext_write_addr   = AW'(addr);
        bus.ext_write_data   = data;
        bus.ext_write_enable = 1'b1;
        tick;
        bus.ext_write_enable = 1'b0;
        model[1 - front][addr] = data;
    endtask

    task automatic rd_chk(input int addr, input logic exp, input string tag);
        bus.read_addr = AW'(addr);
        tick;
        chk(tag, bus.read_data, exp);
    endtask

    task automatic sweep(input string tag, output int lit);
        lit = 0;
        for (int a = 0; a < PIX; a++) begin
            bus.read_addr = AW'(a);
            tick;
            if (bus.read_data === 1'b1) lit++;
            chk($sformatf("%s[%0d]", tag, a), bus.read_data, model[front][a]);
        end
    endtask

    initial begin
        int lit, nl;
        bus.fill_start = 0; bus.line_start = 0;
        bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
        bus.ext_write_enable = 0; bus.ext_write_addr = '0; bus.ext_write_data = 0;
        bus.swap = 0; bus.read_addr = '0;
        rst = 1'b1;
        repeat (3) tick;
        chk("rst_fill_ready", bus.fill_ready, 1);
        chk("rst_line_ready", bus.line_ready, 1);
        chk("rst_read_data", bus.read_data, 0);
        rst = 1'b0;
        tick;

        // clear both banks, then the front must read all zero
        do_fill(0);
        do_swap;
        do_fill(0);
        sweep("clear", lit);
        chk("clear_lit", lit, 0);

        // horizontal line (0,0)->(9,0)
        do_fill(0);
        do_line(0, 0, 9, 0, 0);
        do_swap;
        sweep("hline", lit);
        rd_chk(9, 1'b1, "hline_end");
        rd_chk(10, 1'b0, "hline_past_end");

        // steep line drawn towards the origin
        do_fill(0);
        do_line(5, 10, 2, 2, 1);
        do_swap;
        sweep("steep", lit);
        chk("steep_lit", lit, 9);
        rd_chk(10 * HOR + 5, 1'b1, "steep_start");
        rd_chk(2 * HOR + 2, 1'b1, "steep_end");

        // random back-to-back lines (some off-screen) plus raw pixel writes
        for (int r = 0; r < 6; r++) begin
            do_fill(0);
            nl = $urandom_range(1, 3);
            for (int k = 0; k < nl; k++)
                do_line($urandom_range(0, 31), $urandom_range(0, 15),
                        $urandom_range(0, 31), $urandom_range(0, 15),
                        bit'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++)
                ext_wr($urandom_range(0, PIX - 1), bit'($urandom_range(0, 1)));
            do_swap;
            sweep("rand", lit);
        end

        // double buffering of an external write
        do_fill(0);
        do_swap;
        do_fill(0);
        ext_wr(100, 1'b1);
        rd_chk(100, 1'b0, "db_noswap");
        do_swap;
        rd_chk(100, 1'b1, "db_swap1");
        do_swap;
        rd_chk(100, 1'b0, "db_swap2");

        // reset 50 cycles into a fill of bank0 while bank1 is front
        if (front != 1) do_swap;
        ext_wr(30, 1'b1);
        ext_wr(150, 1'b1);
        ext_wr(200, 1'b1);
        bus.fill_start = 1'b1;
        tick;
        bus.fill_start = 1'b0;
        repeat (50) tick;
        rst = 1'b1;
        tick;
        chk("midrst_fill_ready", bus.fill_ready, 1);
        chk("midrst_read_data", bus.read_data, 0);
        rst = 1'b0;
        for (int a = 0; a < 50; a++) model[0][a] = 1'b0;
        front = 0;
        repeat (5) tick;
        chk("midrst_idle", bus.fill_ready, 1);
        rd_chk(30, 1'b0, "midrst_cleared");
        rd_chk(150, 1'b1, "midrst_kept150");
        rd_chk(200, 1'b1, "midrst_kept200");
        sweep("midrst", lit);

        // fill and a single-pixel line started together: fill owns the port
        do_swap;
        ext_wr(0, 1'b1);
        do_swap;
        do_fill(1);
        do_swap;
        rd_chk(0, 1'b0, "prio_addr0");
        sweep("prio", lit);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/raster_core.md
# raster_core

Pixel-raster back end of the function plotter: a clear (fill) engine, a Bresenham line engine and a 1-bit-per-pixel double-buffered frame buffer in one block. The plot controller and the symbol drawer feed it drawing commands and raw pixel writes. The video scan-out reads the front buffer, while all drawing goes to the back buffer. `swap` exchanges the two buffers.

## Interface
- HOR_ACTIVE_PIXELS, 640, visible columns; X_WIDTH = clog2(HOR_ACTIVE_PIXELS) (10)
- VER_ACTIVE_PIXELS, 480, visible rows; Y_WIDTH = clog2(VER_ACTIVE_PIXELS) (9)
- PIXELS_COUNT = HOR×VER (307200); ADDR_WIDTH = clog2(PIXELS_COUNT) (19); both derived, not overridable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fill_start  in  1  request clear of back buffer
- fill_ready  out  1  fill engine idle
- line_start  in  1  request line draw
- line_ready  out  1  line engine idle
- x1, x2  in  X_WIDTH  line endpoint columns
- y1, y2  in  Y_WIDTH  line endpoint rows
- ext_write_enable  in  1  external pixel write (symbol drawer)
- ext_write_addr  in  ADDR_WIDTH  external pixel address y×HOR+x
- ext_write_data  in  1  external pixel value
- swap  in  1  one-cycle pulse: exchange front/back buffers
- read_addr  in  ADDR_WIDTH  front-buffer read address
- read_data  out  1  front-buffer pixel, registered

## Operation
- Memory: two banks of PIXELS_COUNT bits. `front_sel` selects the read bank; all writes go to bank `!front_sel`. Memory contents are not affected by rst.
- Pixel address = y×HOR_ACTIVE_PIXELS + x; 1 = lit, 0 = background.
- Fill engine, states IDLE/RUN:
  - `fill_start` while IDLE latches a counter at 0.
  - RUN writes 0 to addresses 0..PIXELS_COUNT-1, one per cycle, then returns to IDLE.
  - `fill_start` during RUN is ignored.
- Line engine, states IDLE/RUN, using integer Bresenham for all octants:
  - `line_start` while IDLE latches x1,y1,x2,y2 and computes dx=|x2-x1|, dy=-|y2-y1|, sx, sy and err=dx+dy.
  - RUN writes 1 at the current point each cycle, then steps. The run ends after writing (x2,y2).
  - Pixel count is max(|dx|,|dy|)+1; a degenerate line (x1==x2, y1==y2) writes exactly one pixel.
  - Arithmetic uses signed width max(X_WIDTH,Y_WIDTH)+2 so there is no overflow.
  - Points with x≥HOR or y≥VER are stepped through but not written (clipping).
  - `line_start` during RUN is ignored.
- Write port priority: fill > line > external. The lower-priority write in the same cycle is dropped. Callers must not overlap sources; priority only defines the result when they do.
- Swap: `swap`=1 at an edge toggles `front_sel`.
  - A write in the same cycle lands in the old back bank.
  - A read in the same cycle returns data from the old front bank.
  - Swapping mid-draw is legal; subsequent writes go to the new back bank.

## Timing
- Reset values: fill_ready=1, line_ready=1, read_data=0, front_sel=0 (bank0 is front), both engines IDLE. rst mid-operation aborts the engine immediately: no further writes, ready=1 the next cycle.
- Fill:
  - Start accepted at edge T; fill_ready=0 from T.
  - Writes at edges T+1..T+PIXELS_COUNT.
  - fill_ready=1 after edge T+PIXELS_COUNT.
- Line:
  - Start accepted at edge T; line_ready=0 from T.
  - First pixel (x1,y1) written at T+1; the N-th pixel at T+N.
  - line_ready=1 after the last write.
  - Endpoint inputs need only be valid in the start cycle.
- A start is accepted in the cycle ready rises (back-to-back lines are allowed, with no idle gap required).
- External write: committed at the edge where ext_write_enable=1; no handshake.
- Read:
  - read_data at edge T+1 reflects the front bank at read_addr sampled at edge T (1-cycle latency).
  - A write to the back bank never alters read_data until after a swap.

## Test plan
- Reset, then fill_start; count cycles: fill_ready low for exactly 307200 cycles. Then pulse swap and read all 307200 addresses: every read_data=0.
- Fill; line (0,0)→(9,0); swap. Addresses 0..9 read 1, address 10 reads 0; line_ready low for exactly 10 cycles.
- Fill; line (5,10)→(2,2) (steep, negative direction); swap. Exactly 9 pixels lit, one per row y=2..10, including (5,10) and (2,2).
- Double buffering:
  - Fill, swap, fill.
  - External write addr 100=1 with no swap: reading 100 returns 0.
  - Pulse swap: reading 100 returns 1.
  - Pulse swap again: reading 100 returns 0.
- Reset asserted 50 cycles into a fill: fill_ready=1 the next cycle, no further writes, and front_sel returns to bank0.
- Fill and line_start together with line (0,0)→(0,0): the fill wins the write port. The line pixel at address 0 is dropped; after fill completes and swap, address 0 reads 0.
